sdbp_frame_sender: RTL and testbench
====================================

SDBP_FRAME_SENDER -- requirements
Module: sdbp_frame_sender

Interface
REQ-001 Parameter TOTAL_BLOCKS, default 360, number of 16-bit block gray words per frame.
REQ-002 Parameter CLK_DIV, default 2, clk cycles per serial clock half-period; legal range 1..255.
REQ-003 Parameter HEADER, default 16'hA55A, word sent before block data in every frame.
REQ-004 Parameter CS_GAP, default 4, clk cycles cs_n stays high after a frame.
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 sdbpflag  input  1  frame-send request, level pulse of at least 1 cycle.
REQ-008 wten  input  1  write strobe for wtaddr/wtdina.
REQ-009 wtaddr  input  10  block index being written.
REQ-010 wtdina  input  16  block max-gray value.
REQ-011 spi_sclk  output  1  serial clock, idles low (SPI mode 0).
REQ-012 spi_mosi  output  1  serial data, MSB first.
REQ-013 spi_cs_n  output  1  frame select, active low.
REQ-014 busy  output  1  high from frame start through end of CS_GAP.
REQ-015 frame_done  output  1  one-cycle pulse on the last cycle of CS_GAP.
REQ-016 overrun  output  1  sticky flag: request lost; cleared only by rst.

Function
REQ-017 Storage SHALL be two banks of TOTAL_BLOCKS x 16 bits: a write bank and a send bank.
REQ-018 With wten=1 and wtaddr<TOTAL_BLOCKS, wtdina SHALL be written to wtaddr of the write bank that cycle; wtaddr>=TOTAL_BLOCKS SHALL be ignored.
REQ-019 A request SHALL be the rising edge of sdbpflag: registered sdbpflag=1 and its 1-cycle-delayed copy=0. A held-high level SHALL count as one request.
REQ-020 On a request in IDLE, banks SHALL swap and the FSM SHALL enter SETUP on the next cycle.
REQ-021 On a request while busy, a pending flag SHALL be set. At end of GAP the banks swap, pending clears, and SETUP is entered without passing through IDLE.
REQ-022 A request while pending is already set SHALL set overrun. The pending request is kept once.
REQ-023 A write in the same cycle as a swap SHALL go to the bank that was the write bank before the swap.
REQ-024 FSM states: IDLE, SETUP, SHIFT, LOAD, GAP.
REQ-025 IDLE behaviour: spi_cs_n=1, spi_sclk=0, spi_mosi=0, busy=0.
REQ-026 SETUP behaviour: cs_n=0, shift register=HEADER, spi_mosi=bit15, word counter=0, lasts CLK_DIV cycles, then SHIFT.
REQ-027 SHIFT behaviour: spi_sclk toggles every CLK_DIV cycles. spi_mosi updates on the falling edge only. Each word is 16 sclk periods.
REQ-028 After bit 0's falling edge: LOAD if words sent < TOTAL_BLOCKS+1, else GAP.
REQ-029 LOAD behaviour: reads the send bank at the word counter (1-cycle read latency), loads the shift register, sets spi_mosi to bit15, increments the counter, lasts exactly CLK_DIV cycles with sclk low, then SHIFT.
REQ-030 Word order SHALL be HEADER, then blocks 0..TOTAL_BLOCKS-1.
REQ-031 GAP behaviour: cs_n=1, sclk=0, CS_GAP cycles long; frame_done pulses on its last cycle.
REQ-032 Serial data SHALL be stable for at least CLK_DIV cycles on either side of each sclk rising edge.
REQ-033 Block RAM contents are unaffected by reset; a frame sent before any write carries undefined data.

Reset
REQ-034 While rst=1: FSM=IDLE; spi_cs_n=1, spi_sclk=0, spi_mosi=0, busy=0, frame_done=0, overrun=0, pending=0; bank select=0; edge detector cleared.
REQ-035 rst asserted mid-frame SHALL force the outputs to the values in REQ-034 on the next edge; the frame is abandoned with no frame_done.
REQ-036 sdbpflag held high through rst release SHALL NOT create a request until it goes low and rises again.

Verification
REQ-037 Scenario: TOTAL_BLOCKS=4, CLK_DIV=2; write 0x1111/0x2222/0x3333/0x4444 to addr 0-3, pulse sdbpflag -> bits received on sclk rising edges are A55A,1111,2222,3333,4444; 80 sclk periods; frame_done once.
REQ-038 Scenario: during a frame, write new values and pulse sdbpflag -> the current frame keeps the old data; the next frame starts right after GAP with the new data, with no IDLE cycle.
REQ-039 Scenario: two requests during one frame -> overrun=1 and exactly one extra frame follows.
REQ-040 Scenario: wten with wtaddr=360 (default parameters) -> no RAM change; the next frame's data matches the prior contents.
REQ-041 Scenario: rst pulsed on bit 7 of word 2 -> next cycle cs_n=1, sclk=0, busy=0, no frame_done.
REQ-042 Scenario: CLK_DIV=1, sdbpflag held high for 100 cycles -> one frame only; sclk period is 2 clk cycles.

Source files
------------

// File: rtl/sdbp_frame_sender.sv
// sdbp_frame_sender: double-buffered block-gray store streamed as SPI mode-0 frames
`timescale 1ns/1ps
module sdbp_frame_sender #(
  parameter int TOTAL_BLOCKS = 360,
  parameter int CLK_DIV = 2,
  parameter logic [15:0] HEADER = 16'hA55A,
  parameter int CS_GAP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sdbpflag,
  input  logic        wten,
  input  logic [9:0]  wtaddr,
  input  logic [15:0] wtdina,
  output logic        spi_sclk,
  output logic        spi_mosi,
  output logic        spi_cs_n,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun
);
  localparam int AW = TOTAL_BLOCKS > 1 ? $clog2(TOTAL_BLOCKS) : 1;
  localparam logic [10:0] NB = 11'(TOTAL_BLOCKS);
  localparam logic [7:0] DV = 8'(CLK_DIV - 1);
  localparam logic [15:0] GL = 16'(CS_GAP - 1);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, LOAD, GAP} state_t;
  state_t r_state;
  logic [15:0] r_mem0 [TOTAL_BLOCKS];
  logic [15:0] r_mem1 [TOTAL_BLOCKS];
  logic [15:0] r_rd, r_shift, r_gap;
  logic [10:0] r_word;
  logic [7:0] r_div;
  logic [3:0] r_bit;
  logic r_sel, r_pend, r_flag, r_flag_d;
  logic w_req, w_wr, w_tick, w_gap_end, w_start;
  logic [AW-1:0] w_waddr, w_raddr;
  assign w_req = r_flag & ~r_flag_d;
  assign w_wr = wten & ({1'b0, wtaddr} < NB);
  assign w_waddr = AW'(wtaddr);
  assign w_raddr = AW'(r_word);
  assign w_tick = r_div == DV;
  assign w_gap_end = r_state == GAP && r_gap == GL;
  assign w_start = (r_state == IDLE && w_req) || (w_gap_end && (r_pend || w_req));
  // r_sel names the write bank; the other bank is prefetched into r_rd at r_word
  always_ff @(posedge clk) begin
    if (w_wr && !r_sel) r_mem0[w_waddr] <= wtdina;
    if (w_wr && r_sel) r_mem1[w_waddr] <= wtdina;
    r_rd <= r_sel ? r_mem0[w_raddr] : r_mem1[w_raddr];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      spi_cs_n <= 1'b1;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
      busy <= 1'b0;
      frame_done <= 1'b0;
      overrun <= 1'b0;
      r_pend <= 1'b0;
      r_sel <= 1'b0;
      r_flag <= 1'b1;
      r_flag_d <= 1'b1;
      r_shift <= '0;
      r_word <= '0;
      r_div <= '0;
      r_bit <= '0;
      r_gap <= '0;
    end else begin
      r_flag <= sdbpflag;
      r_flag_d <= r_flag;
      frame_done <= 1'b0;
      if (w_req && r_state != IDLE && !w_gap_end) begin
        overrun <= overrun | r_pend;
        r_pend <= 1'b1;
      end
      if (w_start) begin
        r_sel <= ~r_sel;
        r_pend <= r_pend & w_req;
        r_state <= SETUP;
        spi_cs_n <= 1'b0;
        busy <= 1'b1;
        r_shift <= HEADER;
        spi_mosi <= HEADER[15];
        r_word <= '0;
        r_div <= '0;
      end else begin
        r_div <= w_tick ? '0 : r_div + 8'd1;
        case (r_state)
          SETUP, LOAD: if (w_tick) begin
            r_state <= SHIFT;
            spi_sclk <= 1'b1;
            r_bit <= '0;
          end
          SHIFT: if (w_tick) begin
            spi_sclk <= ~spi_sclk;
            // data only moves on the falling edge so it brackets each rising edge
            if (spi_sclk && r_bit != 4'd15) begin
              r_bit <= r_bit + 4'd1;
              r_shift <= r_shift << 1;
              spi_mosi <= r_shift[14];
            end else if (spi_sclk && r_word < NB) begin
              r_state <= LOAD;
              r_shift <= r_rd;
              spi_mosi <= r_rd[15];
              r_word <= r_word + 11'd1;
            end else if (spi_sclk) begin
              r_state <= GAP;
              spi_cs_n <= 1'b1;
              spi_mosi <= 1'b0;
              r_gap <= '0;
              frame_done <= GL == '0;
            end
          end
          GAP: if (w_gap_end) begin
            r_state <= IDLE;
            busy <= 1'b0;
          end else begin
            r_gap <= r_gap + 16'd1;
            frame_done <= r_gap + 16'd1 == GL;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sdbp_frame_sender.sv
// tb_sdbp_frame_sender: two instances (CLK_DIV 2 and 1) checked each cycle against a frame-offset model
`timescale 1ns/1ps
module tb_sdbp_frame_sender;
  localparam int N = 4;
  localparam logic [15:0] HDR = 16'hA55A;
  logic clk = 1'b0, rst = 1'b1, sdbpflag = 1'b0, wten = 1'b0;
  logic [9:0] wtaddr = '0;
  logic [15:0] wtdina = '0;
  logic [1:0] sclk, mosi, csn, busy, done, ovr;
  int n_run = 0, n_fail = 0;
  always #5 clk = ~clk;

  sdbp_frame_sender #(.TOTAL_BLOCKS(N), .CLK_DIV(2), .HEADER(HDR), .CS_GAP(4)) dut0 (
    .clk(clk), .rst(rst), .sdbpflag(sdbpflag), .wten(wten), .wtaddr(wtaddr), .wtdina(wtdina),
    .spi_sclk(sclk[0]), .spi_mosi(mosi[0]), .spi_cs_n(csn[0]), .busy(busy[0]),
    .frame_done(done[0]), .overrun(ovr[0]));
  sdbp_frame_sender #(.TOTAL_BLOCKS(N), .CLK_DIV(1), .HEADER(HDR), .CS_GAP(3)) dut1 (
    .clk(clk), .rst(rst), .sdbpflag(sdbpflag), .wten(wten), .wtaddr(wtaddr), .wtdina(wtdina),
    .spi_sclk(sclk[1]), .spi_mosi(mosi[1]), .spi_cs_n(csn[1]), .busy(busy[1]),
    .frame_done(done[1]), .overrun(ovr[1]));

  function automatic int cd(input int k);
    return k == 0 ? 2 : 1;
  endfunction
  function automatic int gp(input int k);
    return k == 0 ? 4 : 3;
  endfunction

  logic [15:0] bank [2][2][N];
  logic [15:0] words [2][N+1];
  bit m_busy [2], m_pend [2], m_over [2], m_sel [2];
  int m_off [2];
  bit q1 = 1'b1, q2 = 1'b1, m_valid = 1'b0;

  task automatic start(input int k);
    m_busy[k] = 1'b1;
    m_off[k] = 0;
    words[k][0] = HDR;
    for (int i = 0; i < N; i++) words[k][i+1] = bank[k][m_sel[k]][i];
    m_sel[k] = ~m_sel[k];
  endtask

  always @(posedge clk) begin : model
    bit req;
    int len;
    req = q1 & ~q2;
    m_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      len = 32 * cd(k) * (N + 1) + gp(k);
      if (rst) begin
        m_busy[k] = 0; m_pend[k] = 0; m_over[k] = 0; m_off[k] = 0; m_sel[k] = 0;
      end else begin
        if (wten && wtaddr < N) bank[k][m_sel[k]][wtaddr] = wtdina;
        if (m_busy[k] && m_off[k] == len - 1) begin
          if (m_pend[k] || req) begin
            start(k);
            m_pend[k] = m_pend[k] && req;
          end else m_busy[k] = 0;
        end else if (m_busy[k]) begin
          m_off[k]++;
          if (req) begin
            if (m_pend[k]) m_over[k] = 1;
            m_pend[k] = 1;
          end
        end else if (req) start(k);
      end
    end
    q2 = rst ? 1'b1 : q1;
    q1 = rst ? 1'b1 : sdbpflag;
  end

  logic [15:0] rx [2];
  int bits [2], rises [2], dones [2], last_rise [2];
  int pmin = 1000, pmax = 0, ncyc = 0;
  logic [15:0] rxq0 [$];
  logic [15:0] rxq1 [$];
  logic [1:0] psclk = '0;

  always @(negedge clk) begin : cmp
    logic [5:0] exp_v, act_v;
    int len, w, h, p;
    ncyc++;
    if (m_valid) for (int k = 0; k < 2; k++) begin
      exp_v = {1'b1, 1'b0, 1'b0, m_busy[k], 1'b0, m_over[k]};
      len = 32 * cd(k) * (N + 1);
      if (m_busy[k] && m_off[k] < len) begin
        w = m_off[k] / (32 * cd(k));
        h = (m_off[k] % (32 * cd(k))) / cd(k);
        exp_v[5:3] = {1'b0, h[0], words[k][w][15 - h / 2]};
      end else if (m_busy[k]) exp_v[1] = m_off[k] == len + gp(k) - 1;
      act_v = {csn[k], sclk[k], mosi[k], busy[k], done[k], ovr[k]};
      n_run++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL cycle dut%0d @%0d: csn/sclk/mosi/busy/done/ovr got %b want %b", k, ncyc, act_v, exp_v);
      end
      if (csn[k]) bits[k] = 0;
      else if (sclk[k] && !psclk[k]) begin
        rx[k] = {rx[k][14:0], mosi[k]};
        bits[k]++;
        if (bits[k] % 16 == 0) begin
          if (k == 0) rxq0.push_back(rx[k]);
          else rxq1.push_back(rx[k]);
        end
      end
      if (sclk[k] && !psclk[k]) begin
        if (k == 1 && rises[k] > 0) begin
          p = ncyc - last_rise[k];
          pmin = p < pmin ? p : pmin;
          pmax = p > pmax ? p : pmax;
        end
        rises[k]++;
        last_rise[k] = ncyc;
      end
      dones[k] += done[k] ? 1 : 0;
      psclk[k] = sclk[k];
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_frame(input int k, input int f, input logic [15:0] base, input logic [15:0] step);
    logic [15:0] got;
    int idx;
    for (int i = 0; i <= N; i++) begin
      idx = f * (N + 1) + i;
      got = 16'hxxxx;
      if (k == 0 && idx < rxq0.size()) got = rxq0[idx];
      if (k == 1 && idx < rxq1.size()) got = rxq1[idx];
      chk($sformatf("dut%0d frame%0d word%0d", k, f, i), got, i == 0 ? HDR : 16'(base + (i - 1) * step));
    end
  endtask

  task automatic wr(input int a, input logic [15:0] d);
    wtaddr = 10'(a);
    wtdina = d;
    wten = 1'b1;
    cyc(1);
    wten = 1'b0;
  endtask

  task automatic pulse();
    sdbpflag = 1'b1;
    cyc(1);
    sdbpflag = 1'b0;
    cyc(1);
  endtask

  task automatic clear();
    rises = '{0, 0};
    dones = '{0, 0};
    rxq0.delete();
    rxq1.delete();
    pmin = 1000;
    pmax = 0;
  endtask

  task automatic wait_idle();
    int t = 0;
    cyc(3);
    while (busy !== 2'b00 && t < 3000) begin
      cyc(1);
      t++;
    end
    chk("idle reached", t < 3000 ? 1 : 0, 1);
  endtask

  initial begin
    int t;
    rst = 1'b1;
    cyc(3);
    chk("reset outputs", {csn[0], sclk[0], mosi[0], busy[0], done[0], ovr[0]}, 6'b100000);
    rst = 1'b0;
    cyc(2);
    for (int i = 0; i < N; i++) wr(i, 16'(16'h1111 * (i + 1)));
    clear();
    pulse();
    wait_idle();
    chk_frame(0, 0, 16'h1111, 16'h1111);
    chk_frame(1, 0, 16'h1111, 16'h1111);
    chk("dut0 sclk periods", rises[0], 80);
    chk("dut0 frame_done count", dones[0], 1);
    for (int i = 0; i < N; i++) wr(i, 16'(16'h5000 + i));
    clear();
    pulse();
    cyc(50);
    for (int i = 0; i < N; i++) wr(i, 16'(16'h6660 + i));
    pulse();
    wait_idle();
    chk("back-to-back dones dut0", dones[0], 2);
    chk("back-to-back dones dut1", dones[1], 2);
    chk_frame(0, 0, 16'h5000, 16'h1);
    chk_frame(0, 1, 16'h6660, 16'h1);
    chk_frame(1, 1, 16'h6660, 16'h1);
    for (int i = 0; i < N; i++) wr(i, 16'(16'h7770 + i));
    clear();
    pulse();
    cyc(20);
    pulse();
    cyc(20);
    pulse();
    wait_idle();
    chk("overrun dut0", ovr[0], 1);
    chk("overrun dut1", ovr[1], 1);
    chk("overrun dones dut0", dones[0], 2);
    chk_frame(0, 0, 16'h7770, 16'h1);
    chk_frame(0, 1, 16'h6660, 16'h1);
    wr(4, 16'hDEAD);
    wr(1023, 16'hBEEF);
    clear();
    pulse();
    wait_idle();
    chk_frame(0, 0, 16'h7770, 16'h1);
    chk_frame(1, 0, 16'h7770, 16'h1);
    clear();
    pulse();
    t = 0;
    while (busy[0] !== 1'b1 && t < 20) begin
      cyc(1);
      t++;
    end
    chk("abort frame started", t < 20 ? 1 : 0, 1);
    cyc(160);
    rst = 1'b1;
    cyc(1);
    chk("abort outputs dut0", {csn[0], sclk[0], busy[0]}, 3'b100);
    chk("abort busy dut1", busy[1], 0);
    sdbpflag = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(100);
    chk("abort dones", dones[0] + dones[1], 0);
    chk("no request from held level", busy, 2'b00);
    chk("overrun cleared", ovr, 2'b00);
    sdbpflag = 1'b0;
    cyc(2);
    clear();
    sdbpflag = 1'b1;
    cyc(100);
    sdbpflag = 1'b0;
    wait_idle();
    chk("held dones dut0", dones[0], 1);
    chk("held dones dut1", dones[1], 1);
    chk("dut1 sclk periods", rises[1], 80);
    chk("dut1 sclk min period", pmin, 2);
    chk("dut1 sclk max period", pmax, 2);
    chk_frame(1, 0, 16'h6660, 16'h1);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
